// File: rtl/nibble_serial_cla_adder.sv
// Multi-cycle WIDTH-bit adder: one 4-bit carry-lookahead slice, one nibble per clock, LSB first.
// Optional build macro NIBBLE_SERIAL_SUB_EN adds a 'sub' input for two's-complement subtraction.
module nibble_serial_cla_adder #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
`ifdef NIBBLE_SERIAL_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Sum,
   output logic             Cout,
   output logic             Ovf
);

   localparam int unsigned NIB  = WIDTH / 4;
   localparam int unsigned CW   = (NIB > 1) ? $clog2(NIB) : 1;
   localparam logic [CW-1:0] LAST = CW'(NIB - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_d;
   logic [WIDTH-1:0] a_r, a_d, b_r, b_d, sum_d;
   logic [CW-1:0]    k, k_d;
   logic             carry, carry_d, cout_d, ovf_d, busy_d, done_d;

   logic [CW+1:0]    sh;
   logic [3:0]       a_nib, b_nib, g, p, c, s_nib;
   logic             c4;

   // Lookahead slice on the current nibble
   always_comb begin
      sh    = {k, 2'b00};
      a_nib = 4'(a_r >> sh);
      b_nib = 4'(b_r >> sh);
      g     = a_nib & b_nib;
      p     = a_nib ^ b_nib;
      c[0]  = carry;
      c[1]  = g[0] | (p[0] & c[0]);
      c[2]  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
      c[3]  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
      c4    = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
            | (&p & c[0]);
      s_nib = p ^ c;
   end

   // Next-state and datapath updates
   always_comb begin
      state_d = state;
      a_d     = a_r;
      b_d     = b_r;
      k_d     = k;
      carry_d = carry;
      sum_d   = Sum;
      cout_d  = Cout;
      ovf_d   = Ovf;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               a_d = A;
               k_d = '0;
`ifdef NIBBLE_SERIAL_SUB_EN
               b_d     = sub ? ~B : B;
               carry_d = sub ? 1'b1 : Cin;
`else
               b_d     = B;
               carry_d = Cin;
`endif
               state_d = RUN;
            end else if (state == DONE) begin
               state_d = IDLE;
            end
         end
         RUN: begin
            sum_d   = (Sum & ~(WIDTH'(4'hF) << sh)) | (WIDTH'(s_nib) << sh);
            carry_d = c4;
            if (k == LAST) begin
               cout_d  = c4;
               ovf_d   = c[3] ^ c4;
               state_d = DONE;
            end else begin
               k_d = k + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d == RUN);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         a_r   <= '0;
         b_r   <= '0;
         k     <= '0;
         carry <= 1'b0;
         Sum   <= '0;
         Cout  <= 1'b0;
         Ovf   <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_d;
         a_r   <= a_d;
         b_r   <= b_d;
         k     <= k_d;
         carry <= carry_d;
         Sum   <= sum_d;
         Cout  <= cout_d;
         Ovf   <= ovf_d;
         busy  <= busy_d;
         done  <= done_d;
      end
   end

endmodule
